// File: rtl/reg_file_sb.sv
// Register file with write-through bypass, a per-register busy scoreboard and a
// post-reset fill engine that initialises every entry before normal operation.
module reg_file_sb #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREG      = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned INIT_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2,
  input  logic            reg_write,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            init_busy
);

  typedef enum logic {StFill, StReady} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic            wr_en;
  logic            iss_en;
  logic [XLEN-1:0] fill_val;

  // State register: reset restarts the fill from entry 0 and drops all reservations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      ptr_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; ptr holds on the last entry so the fill never runs twice.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StFill: begin
        if (ptr_q == AW'(NREG - 1)) begin
          state_d = StReady;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      StReady: begin
        state_d = StReady;
      end
    endcase
  end

  // Output / qualifier logic.
  always_comb begin
    init_busy = (state_q == StFill);
    wr_en     = reg_write && (rd != '0) && !init_busy;
    iss_en    = issue_valid && (issue_rd != '0) && !init_busy;
    fill_val  = (INIT_MODE == 1) ? XLEN'(ptr_q) : '0;
  end

  // Clear before set so a new producer on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[rd] = 1'b0;
    end
    if (iss_en) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  // Array has no reset; its contents are defined by the fill pass.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      regs_q[ptr_q] <= fill_val;
    end else if (wr_en) begin
      regs_q[rd] <= write_data;
    end
  end

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    busy1      = 1'b1;
    busy2      = 1'b1;
    if (!init_busy) begin
      busy1 = busy_q[rs1];
      busy2 = busy_q[rs2];
      if (rs1 == '0) begin
        read_data1 = '0;
      end else if (wr_en && (rd == rs1)) begin
        read_data1 = write_data;
      end else begin
        read_data1 = regs_q[rs1];
      end
      if (rs2 == '0) begin
        read_data2 = '0;
      end else if (wr_en && (rd == rs2)) begin
        read_data2 = write_data;
      end else begin
        read_data2 = regs_q[rs2];
      end
    end
  end

endmodule
